// File: rtl/biriscv_iter_divider_pkg.sv
// rtl/biriscv_iter_divider_pkg.sv - RV32M divide/remainder instruction match constants and decode helpers
package biriscv_iter_divider_pkg;

    localparam logic [31:0] INST_DIV       = 32'h0200_4033;
    localparam logic [31:0] INST_DIV_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_DIVU      = 32'h0200_5033;
    localparam logic [31:0] INST_DIVU_MASK = 32'hfe00_707f;
    localparam logic [31:0] INST_REM       = 32'h0200_6033;
    localparam logic [31:0] INST_REM_MASK  = 32'hfe00_707f;
    localparam logic [31:0] INST_REMU      = 32'h0200_7033;
    localparam logic [31:0] INST_REMU_MASK = 32'hfe00_707f;

    function automatic logic match_div(input logic [31:0] op);
        return (op & INST_DIV_MASK) == INST_DIV;
    endfunction

    function automatic logic match_divu(input logic [31:0] op);
        return (op & INST_DIVU_MASK) == INST_DIVU;
    endfunction

    function automatic logic match_rem(input logic [31:0] op);
        return (op & INST_REM_MASK) == INST_REM;
    endfunction

    function automatic logic match_remu(input logic [31:0] op);
        return (op & INST_REMU_MASK) == INST_REMU;
    endfunction

endpackage

// File: rtl/biriscv_iter_divider.sv
// rtl/biriscv_iter_divider.sv - Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module biriscv_iter_divider
    import biriscv_iter_divider_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        opcode_valid_i,
    input  logic [31:0] opcode_opcode_i,
    input  logic [31:0] opcode_ra_operand_i,
    input  logic [31:0] opcode_rb_operand_i,
    input  logic        hold_i,
    output logic        busy_o,
    output logic        writeback_valid_o,
    output logic [31:0] writeback_value_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  count_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [31:0] divisor_q;
    logic        is_rem_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic        wb_valid_q;
    logic [31:0] wb_value_q;

    logic        op_div;
    logic        op_divu;
    logic        op_rem;
    logic        op_remu;
    logic        is_div_op;
    logic        is_signed;
    logic [31:0] a_mag;
    logic [31:0] b_mag;

    logic [32:0] trial;
    logic [31:0] rem_next;
    logic [31:0] quot_next;
    logic [31:0] result_next;

    always_comb begin
        op_div    = match_div(opcode_opcode_i);
        op_divu   = match_divu(opcode_opcode_i);
        op_rem    = match_rem(opcode_opcode_i);
        op_remu   = match_remu(opcode_opcode_i);
        is_div_op = op_div | op_divu | op_rem | op_remu;
        is_signed = op_div | op_rem;
        a_mag     = (is_signed && opcode_ra_operand_i[31]) ? -opcode_ra_operand_i : opcode_ra_operand_i;
        b_mag     = (is_signed && opcode_rb_operand_i[31]) ? -opcode_rb_operand_i : opcode_rb_operand_i;
    end

    // One restoring step; the final step's result is computed here so the
    // writeback value can be registered on the RUN->DONE edge.
    always_comb begin
        trial = {rem_q, quot_q[31]} - {1'b0, divisor_q};
        if (!trial[32]) begin
            rem_next  = trial[31:0];
            quot_next = {quot_q[30:0], 1'b1};
        end else begin
            rem_next  = {rem_q[30:0], quot_q[31]};
            quot_next = {quot_q[30:0], 1'b0};
        end
        if (is_rem_q) begin
            result_next = neg_r_q ? -rem_next : rem_next;
        end else begin
            result_next = neg_q_q ? -quot_next : quot_next;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            count_q    <= 5'd0;
            rem_q      <= 32'd0;
            quot_q     <= 32'd0;
            divisor_q  <= 32'd0;
            is_rem_q   <= 1'b0;
            neg_q_q    <= 1'b0;
            neg_r_q    <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_value_q <= 32'd0;
        end else if (!hold_i) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (opcode_valid_i && is_div_op) begin
                        state_q   <= ST_RUN;
                        count_q   <= 5'd31;
                        rem_q     <= 32'd0;
                        quot_q    <= a_mag;
                        divisor_q <= b_mag;
                        is_rem_q  <= op_rem | op_remu;
                        neg_q_q   <= is_signed && (opcode_ra_operand_i[31] ^ opcode_rb_operand_i[31])
                                     && (opcode_rb_operand_i != 32'd0);
                        neg_r_q   <= is_signed && opcode_ra_operand_i[31];
                    end
                end
                ST_RUN: begin
                    rem_q   <= rem_next;
                    quot_q  <= quot_next;
                    count_q <= count_q - 5'd1;
                    if (count_q == 5'd0) begin
                        state_q    <= ST_DONE;
                        wb_valid_q <= 1'b1;
                        wb_value_q <= result_next;
                    end
                end
                ST_DONE: begin
                    state_q    <= ST_IDLE;
                    wb_valid_q <= 1'b0;
                    wb_value_q <= 32'd0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o            = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign writeback_valid_o = wb_valid_q;
    assign writeback_value_o = wb_value_q;

endmodule

// File: tb/tb_biriscv_iter_divider.sv
// tb/tb_biriscv_iter_divider.sv - Self-checking bench for biriscv_iter_divider
module tb_biriscv_iter_divider;

    logic        clk = 1'b0;
    logic        rst;
    logic        opcode_valid;
    logic [31:0] opcode;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        hold;
    logic        busy;
    logic        wb_valid;
    logic [31:0] wb_value;

    int checks   = 0;
    int failures = 0;

    logic [31:0] ops [4] = '{32'h0200_4033, 32'h0200_5033, 32'h0200_6033, 32'h0200_7033};
    localparam int K_DIV = 0, K_DIVU = 1, K_REM = 2, K_REMU = 3;

    biriscv_iter_divider dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .opcode_valid_i      (opcode_valid),
        .opcode_opcode_i     (opcode),
        .opcode_ra_operand_i (ra),
        .opcode_rb_operand_i (rb),
        .hold_i              (hold),
        .busy_o              (busy),
        .writeback_valid_o   (wb_valid),
        .writeback_value_o   (wb_value)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // RV32M arithmetic rules, including divide-by-zero and signed overflow.
    function automatic logic [31:0] model(input int k, input logic [31:0] a, input logic [31:0] b);
        bit s = (k == K_DIV) || (k == K_REM);
        bit r = (k == K_REM) || (k == K_REMU);
        int sa = a;
        int sb = b;
        if (b == 32'd0) return r ? a : 32'hffff_ffff;
        if (s) begin
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return r ? 32'd0 : 32'h8000_0000;
            return r ? 32'(sa % sb) : 32'(sa / sb);
        end
        return r ? a % b : a / b;
    endfunction

    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        opcode_valid = 1'b1;
        opcode       = ops[k];
        ra           = a;
        rb           = b;
        @(posedge clk);
        #1;
        opcode_valid = 1'b0;
        opcode       = 32'd0;
    endtask

    task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [31:0] exp;
        int          done_cyc;
        bit          busy_ok;
        logic [31:0] val;
        exp      = model(k, a, b);
        done_cyc = -1;
        busy_ok  = 1'b1;
        val      = 32'd0;
        issue(k, a, b);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (wb_valid === 1'b1) begin
                done_cyc = c;
                val      = wb_value;
                break;
            end
        end
        check_eq({tag, "_latency"}, 32'(done_cyc), 32'd33);
        check_eq({tag, "_value"}, val, exp);
        check_eq({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
        @(negedge clk);
        check_eq({tag, "_idle"}, {busy, wb_valid, wb_value[29:0]} | {2'b00, wb_value[31:30], 28'd0}, 32'd0);
    endtask

    initial begin
        int          done_cyc;
        int          first_v;
        int          last_v;
        int          nvalid;
        bit          val_ok;
        logic [31:0] val;
        logic [31:0] exp;
        logic [31:0] a;
        logic [31:0] b;

        rst          = 1'b1;
        opcode_valid = 1'b0;
        opcode       = 32'd0;
        ra           = 32'd0;
        rb           = 32'd0;
        hold         = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", {31'd0, busy}, 32'd0);
        check_eq("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("reset_wb_value", wb_value, 32'd0);
        rst = 1'b0;

        run_op(K_DIV,  32'd100,       32'd7,          "div_100_7");
        run_op(K_REM,  32'hffff_fff9, 32'd2,          "rem_m7_2");
        run_op(K_DIV,  32'hffff_fff9, 32'd2,          "div_m7_2");
        run_op(K_REMU, 32'hffff_fff9, 32'd2,          "remu_big_2");
        run_op(K_DIVU, 32'd1234,      32'd0,          "divu_by0");
        run_op(K_REM,  32'd1234,      32'd0,          "rem_by0");
        run_op(K_DIV,  32'h8000_0000, 32'hffff_ffff,  "div_ovf");
        run_op(K_REM,  32'h8000_0000, 32'hffff_ffff,  "rem_ovf");
        run_op(K_DIV,  32'hffff_ff9c, 32'd0,          "div_neg_by0");

        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            b = $urandom;
            if (i % 3 == 1) b = $urandom_range(0, 15);
            if (i % 4 == 2) b = -$urandom_range(1, 9);
            if (i % 5 == 3) a = $urandom_range(0, 100);
            run_op(i % 4, a, b, "random");
        end

        // Hold 5 cycles mid-RUN and 3 cycles in DONE.
        exp = model(K_DIV, 32'd1000000, 32'd37);
        issue(K_DIV, 32'd1000000, 32'd37);
        first_v = -1;
        last_v  = -1;
        nvalid  = 0;
        val_ok  = 1'b1;
        for (int c = 1; c <= 42; c++) begin
            @(negedge clk);
            if (wb_valid === 1'b1) begin
                if (first_v < 0) first_v = c;
                last_v = c;
                nvalid++;
                if (wb_value !== exp) val_ok = 1'b0;
            end
            if (c == 10) hold = 1'b1;
            if (c == 15) hold = 1'b0;
            if (c == 38) hold = 1'b1;
            if (c == 41) hold = 1'b0;
            if (c == 42) check_eq("hold_idle_busy", {31'd0, busy}, 32'd0);
        end
        check_eq("hold_first_valid", 32'(first_v), 32'd38);
        check_eq("hold_last_valid", 32'(last_v), 32'd41);
        check_eq("hold_nvalid", 32'(nvalid), 32'd4);
        check_eq("hold_value", {31'd0, val_ok}, 32'd1);

        // Second divide while busy and an ADD while idle must both be ignored.
        issue(K_DIV, 32'd100, 32'd7);
        done_cyc = -1;
        val      = 32'd0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 5) begin
                opcode_valid = 1'b1;
                opcode       = ops[K_DIV];
                ra           = 32'd50;
                rb           = 32'd5;
            end
            if (c == 6) opcode_valid = 1'b0;
            if (wb_valid === 1'b1) begin
                done_cyc = c;
                val      = wb_value;
                break;
            end
        end
        check_eq("busy_ignore_latency", 32'(done_cyc), 32'd33);
        check_eq("busy_ignore_value", val, 32'd14);
        @(negedge clk);
        opcode_valid = 1'b1;
        opcode       = 32'h0000_0033;
        ra           = 32'd1;
        rb           = 32'd1;
        @(negedge clk);
        opcode_valid = 1'b0;
        check_eq("add_ignored_busy", {31'd0, busy}, 32'd0);
        check_eq("add_ignored_wb", {31'd0, wb_valid}, 32'd0);

        // Reset pulsed in cycle 10 aborts without writeback.
        issue(K_DIV, 32'd1000, 32'd3);
        for (int c = 1; c <= 10; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_mid_wb_valid", {31'd0, wb_valid}, 32'd0);
        check_eq("rst_mid_wb_value", wb_value, 32'd0);
        rst    = 1'b0;
        nvalid = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (wb_valid === 1'b1 || busy === 1'b1) nvalid++;
        end
        check_eq("rst_no_writeback", 32'(nvalid), 32'd0);
        run_op(K_DIV, 32'd9, 32'd3, "div_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
